chunked_adder: RTL and testbench

Multi-cycle wide adder that adds two BW-bit operands plus a carry-in, CHUNK bits per cycle. It reuses a single CHUNK-bit add slice, registering the slice's sum and carry-out between cycles. It sits between the operand-select logic and the cos datapath's accumulate stage, where a full-width combinational adder would miss timing. It uses a valid/ready handshake on both sides and holds one transaction at a time.

---
 rtl/chunked_adder.sv | 114 +++++++++++
 tb/tb_chunked_adder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
`default_nettype none
// ============================================================================
// chunked_adder : BW-bit unsigned adder that reuses one CHUNK-bit slice,
//                 producing one chunk of the sum per cycle (valid/ready I/O).
// Revision      : 1.0
// ============================================================================
module chunked_adder #(
    parameter int BW    = 16,
    parameter int CHUNK = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          io_in_valid,
    output logic          io_in_ready,
    input  logic [BW-1:0] io_in_a,
    input  logic [BW-1:0] io_in_b,
    input  logic          io_in_cin,
    output logic          io_out_valid,
    input  logic          io_out_ready,
    output logic [BW-1:0] io_out_s,
    output logic          io_out_c
);

    localparam int NCHUNK = (BW + CHUNK - 1) / CHUNK;
    localparam int EW     = NCHUNK * CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    // Position of sum bit BW inside the last slice's (CHUNK+1)-bit result.
    localparam int CPOS   = BW - (NCHUNK - 1) * CHUNK;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [EW-1:0]   a_sh;
    logic [EW-1:0]   b_sh;
    logic [BW-1:0]   result;
    logic            carry_out;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [CHUNK:0]  slice_sum;

    // Operands are shifted down one chunk per slice so the slice always reads bits [CHUNK-1:0].
    assign slice_sum = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_sh        <= '0;
            b_sh        <= '0;
            result      <= '0;
            carry_out   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_in_valid) begin
                        a_sh       <= EW'(io_in_a);
                        b_sh       <= EW'(io_in_b);
                        carry      <= io_in_cin;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < BW; k++) begin
                        if (k / CHUNK == int'(idx)) begin
                            result[k] <= slice_sum[k % CHUNK];
                        end
                    end
                    carry <= slice_sum[CHUNK];
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    if (idx == LAST_IDX) begin
                        carry_out   <= slice_sum[CPOS];
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (io_out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign io_in_ready  = in_ready_q;
    assign io_out_valid = out_valid_q;
    assign io_out_s     = result;
    assign io_out_c     = carry_out;

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder.sv
`default_nettype none
// ============================================================================
// tb_chunked_adder : directed + random self-checking bench for chunked_adder
//                    (default 16/5 instance plus a 10/5 variant).
// Revision         : 1.0
// ============================================================================
module tb_chunked_adder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_s;
    logic        out_c;

    logic        v10 = 1'b0;
    logic        rdy10;
    logic [9:0]  a10 = '0;
    logic [9:0]  b10 = '0;
    logic        cin10 = 1'b0;
    logic        ov10;
    logic        or10 = 1'b1;
    logic [9:0]  s10;
    logic        c10;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [16:0] sb_q[$];

    chunked_adder dut (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready),
        .io_in_a(in_a), .io_in_b(in_b), .io_in_cin(in_cin),
        .io_out_valid(out_valid), .io_out_ready(out_ready),
        .io_out_s(out_s), .io_out_c(out_c)
    );

    chunked_adder #(.BW(10), .CHUNK(5)) dut10 (
        .clock(clock), .reset(reset),
        .io_in_valid(v10), .io_in_ready(rdy10),
        .io_in_a(a10), .io_in_b(b10), .io_in_cin(cin10),
        .io_out_valid(ov10), .io_out_ready(or10),
        .io_out_s(s10), .io_out_c(c10)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference model: queue of full-width sums, advanced on observed handshakes.
    always @(posedge clock) begin
        if (!reset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (in_valid && in_ready) sb_q.push_back({1'b0, in_a} + {1'b0, in_b} + {16'd0, in_cin});
        end
    end

    always @(negedge clock) begin
        if (reset && out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("model_sum", {16'd0, out_s}, {16'd0, sb_q[0][15:0]});
                chk("model_carry", {31'd0, out_c}, {31'd0, sb_q[0][16]});
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int n;
        @(posedge clock); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Returns at the negedge where out_valid is seen; lat = edges after accept edge.
    task automatic wait_out(output int lat);
        lat = 0;
        @(negedge clock);
        while (!out_valid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        if (lat >= 50) chk("valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic run10(input logic [9:0] a, input logic [9:0] b, input logic cin);
        int lat;
        logic [10:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {10'd0, cin};
        @(posedge clock); #1;
        chk("v10_ready", {31'd0, rdy10}, 32'd1);
        v10 = 1'b1; a10 = a; b10 = b; cin10 = cin;
        @(posedge clock); #1;
        v10 = 1'b0;
        lat = 0;
        @(negedge clock);
        while (!ov10 && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        chk("v10_latency", lat, 32'd2);
        chk("v10_sum", {22'd0, s10}, {22'd0, exp[9:0]});
        chk("v10_carry", {31'd0, c10}, {31'd0, exp[10]});
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int xfer_cyc;
        logic seen;

        // Reset then idle
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_s", {16'd0, out_s}, 32'h0000);
        chk("rst_out_c", {31'd0, out_c}, 32'd0);
        chk("rst10_out", {21'd0, ov10, s10}, 32'd0);

        // Ripple across all chunks
        out_ready = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_out(lat);
        chk("ripple_latency", lat, 32'd4);
        chk("ripple_s", {16'd0, out_s}, 32'h0000);
        chk("ripple_c", {31'd0, out_c}, 32'd1);

        // Back-to-back with in_valid held high
        @(posedge clock); #1;
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0;
        @(negedge clock);
        chk("b2b_ready0", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1;
        wait_out(lat);
        chk("b2b_latency1", lat, 32'd4);
        chk("b2b_s1", {16'd0, out_s}, 32'h5555);
        chk("b2b_c1", {31'd0, out_c}, 32'd0);
        chk("b2b_ready_in_done", {31'd0, in_ready}, 32'd0);
        xfer_cyc = cyc;
        @(negedge clock);
        chk("b2b_ready_rise", {31'd0, in_ready}, 32'd1);
        chk("b2b_rise_delay", cyc - xfer_cyc, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        wait_out(lat);
        chk("b2b_latency2", lat, 32'd4);
        chk("b2b_s2", {16'd0, out_s}, 32'hFFFF);
        chk("b2b_c2", {31'd0, out_c}, 32'd1);

        // Backpressure
        @(posedge clock); #1;
        out_ready = 1'b0;
        send(16'h8000, 16'h8000, 1'b0);
        wait_out(lat);
        for (int i = 0; i < 3; i++) begin
            chk("bp_s", {16'd0, out_s}, 32'h0000);
            chk("bp_c", {31'd0, out_c}, 32'd1);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            if (i < 2) @(negedge clock);
        end
        #1 out_ready = 1'b1;
        @(negedge clock);
        chk("bp_released_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_released_ready", {31'd0, in_ready}, 32'd1);

        // Reset mid-RUN
        send(16'h00FF, 16'h0F0F, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_s", {16'd0, out_s}, 32'h0000);
        chk("midrst_c", {31'd0, out_c}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_valid", {31'd0, seen}, 32'd0);
        send(16'h00FF, 16'h0F0F, 1'b0);
        wait_out(lat);
        chk("post_rst_s", {16'd0, out_s}, 32'h100E);
        chk("post_rst_c", {31'd0, out_c}, 32'd0);

        // 10-bit variant
        run10(10'h3FF, 10'h001, 1'b0);
        chk("v10_lit_s", {22'd0, s10}, 32'h000);
        chk("v10_lit_c", {31'd0, c10}, 32'd1);
        run10(10'h2AA, 10'h155, 1'b1);
        run10(10'h123, 10'h0DC, 1'b0);
        run10(10'h200, 10'h1FF, 1'b1);

        // Random compare at default parameters
        for (int i = 0; i < 2000; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            wait_out(lat);
            chk("rand_latency", lat, 32'd4);
        end

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
